// File: rtl/multi_commit_stage.sv
// N-wide in-order commit stage: retires the ready prefix of the ROB head window and serialises stores.
// Optional COMMIT_STATS_EN adds saturating retired_count and store_stall_cycles counters.
module multi_commit_stage #(
    parameter int COMMIT_WIDTH = 2,
    parameter int XLEN         = 32,
    parameter int REG_IDX_W    = 5,
    parameter int ROB_TAG_W    = 5
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [COMMIT_WIDTH-1:0]           head_valid,
    input  logic [COMMIT_WIDTH-1:0]           head_ready,
    input  logic [COMMIT_WIDTH*XLEN-1:0]      head_value,
    input  logic [COMMIT_WIDTH*REG_IDX_W-1:0] head_dest_reg,
    input  logic [COMMIT_WIDTH-1:0]           head_wr_mem,
    input  logic [COMMIT_WIDTH*XLEN-1:0]      head_mem_addr,
    input  logic [COMMIT_WIDTH*2-1:0]         head_mem_size,
    input  logic [COMMIT_WIDTH*ROB_TAG_W-1:0] head_rob_tag,
    output logic [$clog2(COMMIT_WIDTH+1)-1:0] commit_count,
    output logic [COMMIT_WIDTH-1:0]           commit_valid,
    output logic [COMMIT_WIDTH*ROB_TAG_W-1:0] commit_rob_tag,
    output logic [COMMIT_WIDTH-1:0]           reg_wr_en,
    output logic [COMMIT_WIDTH*REG_IDX_W-1:0] reg_wr_idx,
    output logic [COMMIT_WIDTH*XLEN-1:0]      reg_wr_data,
    output logic                              st_req,
    output logic [XLEN-1:0]                   st_addr,
    output logic [XLEN-1:0]                   st_data,
    output logic [1:0]                        st_size,
    input  logic                              st_ack
`ifdef COMMIT_STATS_EN
    ,
    output logic [63:0]                       retired_count,
    output logic [31:0]                       store_stall_cycles
`endif
);

    localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);

    typedef enum logic {
        IDLE,
        ST_WAIT
    } state_t;

    state_t                 state;
    logic [ROB_TAG_W-1:0]   st_tag;
    logic [COMMIT_WIDTH-1:0] retire;
    logic [COMMIT_WIDTH-1:0] wr_cand;
    logic                   store_start;

    // A slot retires only if it and every older slot are valid, ready, non-store ALU ops.
    always_comb begin : prefix_scan
        logic ok;
        ok     = 1'b1;
        retire = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            ok        = ok & head_valid[i] & head_ready[i] & ~head_wr_mem[i];
            retire[i] = ok;
        end
    end

    assign store_start = head_valid[0] & head_ready[0] & head_wr_mem[0];

    always_comb begin
        commit_valid = '0;
        if (!reset) begin
            if (state == IDLE) begin
                commit_valid = retire;
            end else if (st_ack) begin
                commit_valid[0] = 1'b1;
            end
        end
    end

    always_comb begin
        commit_count = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            commit_count = commit_count + CNT_W'(commit_valid[i]);
        end
    end

    always_comb begin
        commit_rob_tag = head_rob_tag;
        if (state == ST_WAIT) begin
            commit_rob_tag[ROB_TAG_W-1:0] = st_tag;
        end
    end

    assign reg_wr_idx  = head_dest_reg;
    assign reg_wr_data = head_value;

    // Only the youngest committing writer of a given register in this group may write it.
    always_comb begin
        wr_cand   = '0;
        reg_wr_en = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            wr_cand[i] = commit_valid[i] && (state == IDLE) && !head_wr_mem[i]
                         && (head_dest_reg[i*REG_IDX_W +: REG_IDX_W] != '0);
        end
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            reg_wr_en[i] = wr_cand[i];
            for (int j = i + 1; j < COMMIT_WIDTH; j++) begin
                if (wr_cand[j] && (head_dest_reg[j*REG_IDX_W +: REG_IDX_W]
                                   == head_dest_reg[i*REG_IDX_W +: REG_IDX_W])) begin
                    reg_wr_en[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            st_req  <= 1'b0;
            st_addr <= '0;
            st_data <= '0;
            st_size <= '0;
            st_tag  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (store_start) begin
                        st_addr <= head_mem_addr[XLEN-1:0];
                        st_data <= head_value[XLEN-1:0];
                        st_size <= head_mem_size[1:0];
                        st_tag  <= head_rob_tag[ROB_TAG_W-1:0];
                        st_req  <= 1'b1;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (st_ack) begin
                        st_req <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    st_req <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef COMMIT_STATS_EN
    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            retired_count      <= '0;
            store_stall_cycles <= '0;
        end else begin
            if ((64'hFFFF_FFFF_FFFF_FFFF - retired_count) < 64'(commit_count)) begin
                retired_count <= 64'hFFFF_FFFF_FFFF_FFFF;
            end else begin
                retired_count <= retired_count + 64'(commit_count);
            end
            if ((state == ST_WAIT) && !st_ack && (store_stall_cycles != 32'hFFFF_FFFF)) begin
                store_stall_cycles <= store_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multi_commit_stage.sv
// Scoreboard testbench for multi_commit_stage with COMMIT_WIDTH=2.
module tb_multi_commit_stage;

    localparam int W  = 2;
    localparam int XL = 32;
    localparam int RW = 5;
    localparam int TW = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic [W-1:0]      head_valid, head_ready, head_wr_mem;
    logic [W*XL-1:0]   head_value, head_mem_addr;
    logic [W*RW-1:0]   head_dest_reg;
    logic [W*2-1:0]    head_mem_size;
    logic [W*TW-1:0]   head_rob_tag;
    logic [1:0]        commit_count;
    logic [W-1:0]      commit_valid, reg_wr_en;
    logic [W*TW-1:0]   commit_rob_tag;
    logic [W*RW-1:0]   reg_wr_idx;
    logic [W*XL-1:0]   reg_wr_data;
    logic              st_req, st_ack;
    logic [XL-1:0]     st_addr, st_data;
    logic [1:0]        st_size;
`ifdef COMMIT_STATS_EN
    logic [63:0]       retired_count;
    logic [31:0]       store_stall_cycles;
`endif

    multi_commit_stage #(.COMMIT_WIDTH(W), .XLEN(XL), .REG_IDX_W(RW), .ROB_TAG_W(TW)) dut (
        .clock(clock), .reset(reset),
        .head_valid(head_valid), .head_ready(head_ready), .head_value(head_value),
        .head_dest_reg(head_dest_reg), .head_wr_mem(head_wr_mem), .head_mem_addr(head_mem_addr),
        .head_mem_size(head_mem_size), .head_rob_tag(head_rob_tag),
        .commit_count(commit_count), .commit_valid(commit_valid), .commit_rob_tag(commit_rob_tag),
        .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .st_ack(st_ack)
`ifdef COMMIT_STATS_EN
        , .retired_count(retired_count), .store_stall_cycles(store_stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  cnt;
        logic [1:0]  cv;
        logic [1:0]  wen;
        logic        req;
        logic [4:0]  tag0;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int tests_run = 0;
    int tests_failed = 0;

    task set_slot(input int s, input logic v, input logic r, input logic wr, input logic [4:0] dest,
                  input logic [31:0] val, input logic [31:0] addr, input logic [1:0] size,
                  input logic [4:0] tag);
        head_valid[s] = v;
        head_ready[s] = r;
        head_wr_mem[s] = wr;
        head_dest_reg[s*RW +: RW] = dest;
        head_value[s*XL +: XL] = val;
        head_mem_addr[s*XL +: XL] = addr;
        head_mem_size[s*2 +: 2] = size;
        head_rob_tag[s*TW +: TW] = tag;
    endtask

    task clear_heads;
        head_valid = '0; head_ready = '0; head_wr_mem = '0; head_value = '0;
        head_dest_reg = '0; head_mem_addr = '0; head_mem_size = '0; head_rob_tag = '0;
    endtask

    task test_reset;
        @(posedge clock); #1;
        reset = 1'b1;
        set_slot(0, 1, 1, 0, 5'd3, 32'h1, 32'h0, 2'd0, 5'd1);
        set_slot(1, 1, 1, 0, 5'd7, 32'h2, 32'h0, 2'd0, 5'd2);
        exp_q.push_back('{cnt: 2'd0, cv: 2'b00, wen: 2'b00, req: 1'b0, tag0: 5'd0});
        @(negedge clock);
        e = exp_q.pop_front();
        tests_run++;
        if (commit_count !== e.cnt) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected %0d", commit_count, e.cnt); end
        tests_run++;
        if (commit_valid !== e.cv) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected %b", commit_valid, e.cv); end
        tests_run++;
        if (reg_wr_en !== e.wen) begin tests_failed++; $display("[TB] FAIL reset_wen: got %b expected %b", reg_wr_en, e.wen); end
        tests_run++;
        if (st_req !== e.req) begin tests_failed++; $display("[TB] FAIL reset_req: got %b expected %b", st_req, e.req); end
        tests_run++;
        if ({st_addr, st_data, st_size} !== 66'd0) begin tests_failed++; $display("[TB] FAIL reset_st_regs: got %h/%h/%0d expected 0", st_addr, st_data, st_size); end
        @(posedge clock); #1;
        reset = 1'b0;
        clear_heads();
    endtask

    task test_dual_alu;
        @(posedge clock); #1;
        set_slot(0, 1, 1, 0, 5'd3, 32'h1111_1111, 32'h0, 2'd0, 5'd11);
        set_slot(1, 1, 1, 0, 5'd7, 32'h2222_2222, 32'h0, 2'd0, 5'd12);
        exp_q.push_back('{cnt: 2'd2, cv: 2'b11, wen: 2'b11, req: 1'b0, tag0: 5'd11});
        @(negedge clock);
        e = exp_q.pop_front();
        tests_run++;
        if (commit_count !== e.cnt) begin tests_failed++; $display("[TB] FAIL dual_count: got %0d expected %0d", commit_count, e.cnt); end
        tests_run++;
        if (reg_wr_en !== e.wen) begin tests_failed++; $display("[TB] FAIL dual_wen: got %b expected %b", reg_wr_en, e.wen); end
        tests_run++;
        if (reg_wr_idx !== {5'd7, 5'd3}) begin tests_failed++; $display("[TB] FAIL dual_idx: got %h expected %h", reg_wr_idx, {5'd7, 5'd3}); end
        tests_run++;
        if (reg_wr_data !== 64'h2222_2222_1111_1111) begin tests_failed++; $display("[TB] FAIL dual_data: got %h expected 2222222211111111", reg_wr_data); end
        tests_run++;
        if (commit_rob_tag !== {5'd12, e.tag0}) begin tests_failed++; $display("[TB] FAIL dual_tags: got %h expected %h", commit_rob_tag, {5'd12, e.tag0}); end
        @(posedge clock); #1;
        clear_heads();
    endtask

    task test_zero_dest;
        @(posedge clock); #1;
        set_slot(0, 1, 1, 0, 5'd0, 32'hABCD, 32'h0, 2'd0, 5'd4);
        set_slot(1, 1, 0, 0, 5'd9, 32'h1234, 32'h0, 2'd0, 5'd5);
        exp_q.push_back('{cnt: 2'd1, cv: 2'b01, wen: 2'b00, req: 1'b0, tag0: 5'd4});
        @(negedge clock);
        e = exp_q.pop_front();
        tests_run++;
        if (commit_count !== e.cnt) begin tests_failed++; $display("[TB] FAIL zero_count: got %0d expected %0d", commit_count, e.cnt); end
        tests_run++;
        if (commit_valid !== e.cv) begin tests_failed++; $display("[TB] FAIL zero_valid: got %b expected %b", commit_valid, e.cv); end
        tests_run++;
        if (reg_wr_en !== e.wen) begin tests_failed++; $display("[TB] FAIL zero_wen: got %b expected %b", reg_wr_en, e.wen); end
        @(posedge clock); #1;
        clear_heads();
    endtask

    // Cycle 0 issues the store, cycles 1-2 wait (head inputs are noise), cycle 3 acks, cycle 4 idle.
    task test_store;
        exp_q.push_back('{cnt: 2'd0, cv: 2'b00, wen: 2'b00, req: 1'b0, tag0: 5'd0});
        exp_q.push_back('{cnt: 2'd0, cv: 2'b00, wen: 2'b00, req: 1'b1, tag0: 5'd0});
        exp_q.push_back('{cnt: 2'd0, cv: 2'b00, wen: 2'b00, req: 1'b1, tag0: 5'd0});
        exp_q.push_back('{cnt: 2'd1, cv: 2'b01, wen: 2'b00, req: 1'b1, tag0: 5'd9});
        exp_q.push_back('{cnt: 2'd0, cv: 2'b00, wen: 2'b00, req: 1'b0, tag0: 5'd0});
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            clear_heads();
            st_ack = (c == 3);
            if (c == 0) begin
                set_slot(0, 1, 1, 1, 5'd0, 32'hDEAD_BEEF, 32'h100, 2'd2, 5'd9);
                set_slot(1, 1, 1, 0, 5'd2, 32'h5, 32'h0, 2'd0, 5'd10);
            end else if (c < 4) begin
                set_slot(0, 1, 1, 0, 5'd6, 32'h7777, 32'h200, 2'd1, 5'd20);
                set_slot(1, 1, 1, 0, 5'd8, 32'h8888, 32'h300, 2'd0, 5'd21);
            end
            @(negedge clock);
            e = exp_q.pop_front();
            tests_run++;
            if (commit_count !== e.cnt) begin tests_failed++; $display("[TB] FAIL store_count c%0d: got %0d expected %0d", c, commit_count, e.cnt); end
            tests_run++;
            if (st_req !== e.req) begin tests_failed++; $display("[TB] FAIL store_req c%0d: got %b expected %b", c, st_req, e.req); end
            tests_run++;
            if (reg_wr_en !== e.wen) begin tests_failed++; $display("[TB] FAIL store_wen c%0d: got %b expected %b", c, reg_wr_en, e.wen); end
            if (e.req) begin
                tests_run++;
                if (st_addr !== 32'h100 || st_data !== 32'hDEAD_BEEF || st_size !== 2'd2) begin
                    tests_failed++;
                    $display("[TB] FAIL store_fields c%0d: got %h/%h/%0d expected 100/deadbeef/2", c, st_addr, st_data, st_size);
                end
            end
            if (e.cnt != 0) begin
                tests_run++;
                if (commit_valid !== e.cv || commit_rob_tag[4:0] !== e.tag0) begin
                    tests_failed++;
                    $display("[TB] FAIL store_commit c%0d: got %b/%0d expected %b/%0d", c, commit_valid, commit_rob_tag[4:0], e.cv, e.tag0);
                end
            end
        end
        st_ack = 1'b0;
    endtask

    task test_alu_then_store;
        exp_q.push_back('{cnt: 2'd1, cv: 2'b01, wen: 2'b01, req: 1'b0, tag0: 5'd3});
        exp_q.push_back('{cnt: 2'd0, cv: 2'b00, wen: 2'b00, req: 1'b0, tag0: 5'd0});
        exp_q.push_back('{cnt: 2'd1, cv: 2'b01, wen: 2'b00, req: 1'b1, tag0: 5'd4});
        exp_q.push_back('{cnt: 2'd0, cv: 2'b00, wen: 2'b00, req: 1'b0, tag0: 5'd0});
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            clear_heads();
            st_ack = (c == 2);
            if (c == 0) begin
                set_slot(0, 1, 1, 0, 5'd5, 32'h55, 32'h0, 2'd0, 5'd3);
                set_slot(1, 1, 1, 1, 5'd0, 32'hCAFE, 32'h40, 2'd0, 5'd4);
            end else if (c == 1) begin
                set_slot(0, 1, 1, 1, 5'd0, 32'hCAFE, 32'h40, 2'd0, 5'd4);
            end
            @(negedge clock);
            e = exp_q.pop_front();
            tests_run++;
            if (commit_count !== e.cnt) begin tests_failed++; $display("[TB] FAIL alust_count c%0d: got %0d expected %0d", c, commit_count, e.cnt); end
            tests_run++;
            if (reg_wr_en !== e.wen) begin tests_failed++; $display("[TB] FAIL alust_wen c%0d: got %b expected %b", c, reg_wr_en, e.wen); end
            tests_run++;
            if (st_req !== e.req) begin tests_failed++; $display("[TB] FAIL alust_req c%0d: got %b expected %b", c, st_req, e.req); end
            if (e.cnt != 0) begin
                tests_run++;
                if (commit_valid !== e.cv || commit_rob_tag[4:0] !== e.tag0) begin
                    tests_failed++;
                    $display("[TB] FAIL alust_commit c%0d: got %b/%0d expected %b/%0d", c, commit_valid, commit_rob_tag[4:0], e.cv, e.tag0);
                end
            end
            if (c == 2) begin
                tests_run++;
                if (st_addr !== 32'h40 || st_data !== 32'hCAFE) begin tests_failed++; $display("[TB] FAIL alust_fields: got %h/%h expected 40/cafe", st_addr, st_data); end
            end
        end
        st_ack = 1'b0;
    endtask

    task test_waw;
        @(posedge clock); #1;
        set_slot(0, 1, 1, 0, 5'd4, 32'hAAAA_0000, 32'h0, 2'd0, 5'd13);
        set_slot(1, 1, 1, 0, 5'd4, 32'hBBBB_1111, 32'h0, 2'd0, 5'd14);
        exp_q.push_back('{cnt: 2'd2, cv: 2'b11, wen: 2'b10, req: 1'b0, tag0: 5'd13});
        @(negedge clock);
        e = exp_q.pop_front();
        tests_run++;
        if (commit_count !== e.cnt) begin tests_failed++; $display("[TB] FAIL waw_count: got %0d expected %0d", commit_count, e.cnt); end
        tests_run++;
        if (reg_wr_en !== e.wen) begin tests_failed++; $display("[TB] FAIL waw_wen: got %b expected %b", reg_wr_en, e.wen); end
        tests_run++;
        if (reg_wr_idx[9:5] !== 5'd4 || reg_wr_data[63:32] !== 32'hBBBB_1111) begin
            tests_failed++;
            $display("[TB] FAIL waw_slot1: got %0d/%h expected 4/bbbb1111", reg_wr_idx[9:5], reg_wr_data[63:32]);
        end
        @(posedge clock); #1;
        clear_heads();
    endtask

    // Cycle 0 issues, cycle 1 waits, cycle 2 holds reset with the store still presented, cycle 3 idle.
    task test_reset_mid_store;
        exp_q.push_back('{cnt: 2'd0, cv: 2'b00, wen: 2'b00, req: 1'b0, tag0: 5'd0});
        exp_q.push_back('{cnt: 2'd0, cv: 2'b00, wen: 2'b00, req: 1'b1, tag0: 5'd0});
        exp_q.push_back('{cnt: 2'd0, cv: 2'b00, wen: 2'b00, req: 1'b1, tag0: 5'd0});
        exp_q.push_back('{cnt: 2'd0, cv: 2'b00, wen: 2'b00, req: 1'b0, tag0: 5'd0});
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            clear_heads();
            reset  = (c == 2);
            st_ack = (c == 2);
            if (c < 3) begin
                set_slot(0, 1, 1, 1, 5'd0, 32'h1357, 32'h80, 2'd1, 5'd17);
                set_slot(1, 1, 1, 0, 5'd6, 32'h2468, 32'h0, 2'd0, 5'd18);
            end
            @(negedge clock);
            e = exp_q.pop_front();
            tests_run++;
            if (commit_count !== e.cnt) begin tests_failed++; $display("[TB] FAIL rst_st_count c%0d: got %0d expected %0d", c, commit_count, e.cnt); end
            tests_run++;
            if (commit_valid !== e.cv) begin tests_failed++; $display("[TB] FAIL rst_st_valid c%0d: got %b expected %b", c, commit_valid, e.cv); end
            tests_run++;
            if (st_req !== e.req) begin tests_failed++; $display("[TB] FAIL rst_st_req c%0d: got %b expected %b", c, st_req, e.req); end
            if (c == 3) begin
                tests_run++;
                if (st_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_st_addr: got %h expected 0", st_addr); end
`ifdef COMMIT_STATS_EN
                tests_run++;
                if (retired_count !== 64'd0 || store_stall_cycles !== 32'd0) begin
                    tests_failed++;
                    $display("[TB] FAIL rst_st_stats: got %0d/%0d expected 0/0", retired_count, store_stall_cycles);
                end
`endif
            end
        end
        reset  = 1'b0;
        st_ack = 1'b0;
    endtask

    // Randomised ALU-only groups, exercising partial prefixes, zero dest and same-dest writes.
    task test_back_to_back;
        logic [1:0] v, r, cv, cand, wen;
        logic [4:0] d0, d1;
        for (int c = 0; c < 24; c++) begin
            @(posedge clock); #1;
            v  = 2'($urandom_range(0, 3));
            r  = 2'($urandom_range(0, 3));
            d0 = 5'($urandom_range(0, 3));
            d1 = 5'($urandom_range(0, 3));
            set_slot(0, v[0], r[0], 0, d0, $urandom, 32'h0, 2'd0, 5'(c));
            set_slot(1, v[1], r[1], 0, d1, $urandom, 32'h0, 2'd0, 5'(c + 1));
            cv[0]   = v[0] & r[0];
            cv[1]   = cv[0] & v[1] & r[1];
            cand[0] = cv[0] && (d0 != 5'd0);
            cand[1] = cv[1] && (d1 != 5'd0);
            wen[1]  = cand[1];
            wen[0]  = cand[0] && !(cand[1] && (d1 == d0));
            exp_q.push_back('{cnt: 2'(cv[0]) + 2'(cv[1]), cv: cv, wen: wen, req: 1'b0, tag0: 5'(c)});
            @(negedge clock);
            e = exp_q.pop_front();
            tests_run++;
            if (commit_count !== e.cnt || commit_valid !== e.cv || reg_wr_en !== e.wen || st_req !== e.req) begin
                tests_failed++;
                $display("[TB] FAIL b2b c%0d: got cnt=%0d cv=%b wen=%b req=%b expected cnt=%0d cv=%b wen=%b req=%b",
                         c, commit_count, commit_valid, reg_wr_en, st_req, e.cnt, e.cv, e.wen, e.req);
            end
        end
        @(posedge clock); #1;
        clear_heads();
    endtask

    initial begin
        reset  = 1'b1;
        st_ack = 1'b0;
        clear_heads();
        test_reset();
        test_dual_alu();
        test_zero_dest();
        test_store();
        test_alu_then_store();
        test_waw();
        test_reset_mid_store();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multi_commit_stage.md
Name: multi_commit_stage

Overview:
- Parametrised, N-wide in-order commit stage between the ROB head window and the architectural register file / data memory.
- Each cycle it retires the longest ready prefix of the ROB head window and drives per-slot register writebacks.
- Stores are serialised through a registered memory request/acknowledge handshake, so commit has real sequential state.
- Also tells the ROB how many entries to pop and which tags retired, for map-table clearing.

Parameters:
- COMMIT_WIDTH, 2, number of ROB head slots examined and max instructions retired per cycle (1..4).
- XLEN, 32, data/address width.
- REG_IDX_W, 5, architectural register index width; index 0 is the zero register.
- ROB_TAG_W, 5, ROB tag width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- head_valid  in  COMMIT_WIDTH  slot i holds a valid ROB entry; slot 0 is the oldest
- head_ready  in  COMMIT_WIDTH  slot i has completed
- head_value  in  COMMIT_WIDTH*XLEN  result value, or store data for stores
- head_dest_reg  in  COMMIT_WIDTH*REG_IDX_W  destination register index
- head_wr_mem  in  COMMIT_WIDTH  slot i is a store
- head_mem_addr  in  COMMIT_WIDTH*XLEN  store address
- head_mem_size  in  COMMIT_WIDTH*2  store size: 0=byte, 1=half, 2=word
- head_rob_tag  in  COMMIT_WIDTH*ROB_TAG_W  ROB tag of slot i
- commit_count  out  $clog2(COMMIT_WIDTH+1)  number of entries the ROB pops this cycle
- commit_valid  out  COMMIT_WIDTH  slot i retires this cycle
- commit_rob_tag  out  COMMIT_WIDTH*ROB_TAG_W  tags of the retiring slots, for the map table
- reg_wr_en  out  COMMIT_WIDTH  regfile write enable per slot
- reg_wr_idx  out  COMMIT_WIDTH*REG_IDX_W  regfile write index per slot
- reg_wr_data  out  COMMIT_WIDTH*XLEN  regfile write data per slot
- st_req  out  1  store request to memory (registered)
- st_addr  out  XLEN  latched store address
- st_data  out  XLEN  latched store data
- st_size  out  2  latched store size
- st_ack  in  1  memory accepted the store

Behaviour:
- Reset (synchronous, active-high): FSM goes to IDLE; st_req=0; st_addr, st_data, st_size=0.
  - Combinational outputs are forced to 0 while reset is high: commit_count, commit_valid, reg_wr_en.
- FSM states: IDLE and ST_WAIT.
- IDLE:
  - slot i is retireable iff head_valid[i] && head_ready[i] && !head_wr_mem[i], and every slot j<i is retireable.
  - All retireable slots commit in the same cycle (0-cycle latency): commit_valid[i]=1, commit_count = number of committing slots.
  - A store at slot k>0 truncates the prefix at k; slots before k commit normally.
  - If slot 0 is a valid, ready store: commit_count=0; latch addr/data/size into st_*; next state ST_WAIT; st_req=1 from the next cycle.
- ST_WAIT:
  - st_req held at 1 and st_* held stable until st_ack.
  - No commits while waiting; head inputs are ignored.
  - In the st_ack cycle: commit_count=1, commit_valid[0]=1, commit_rob_tag slot0 = tag latched with the store; st_req drops next cycle; next state IDLE.
  - st_ack in IDLE is ignored.
- Register writeback:
  - reg_wr_en[i] = commit_valid[i] && !head_wr_mem[i] && dest_reg[i]!=0.
  - Same-group write-after-write: if a younger committing slot writes the same index, reg_wr_en of the older slot is suppressed.
- Reset mid-store: outstanding request is dropped, the store is not committed, FSM returns to IDLE.
- commit_rob_tag[i] passes head_rob_tag[i] through when commit_valid[i]=1; value is don't-care otherwise.

Optional Feature:
- Macro COMMIT_STATS_EN.
- Defined:
  - Adds output retired_count (64 bits), reset to 0, incremented by commit_count every cycle.
  - Adds output store_stall_cycles (32 bits), reset to 0, +1 per cycle spent in ST_WAIT without st_ack; both saturate at max.
- Undefined: neither port nor counter exists.

Test Plan:
- W=2; both slots ALU ops, ready, dest 3 and 7 -> commit_count=2, reg_wr_en=2'b11, idx 3/7 with their data.
- Slot0 ready with dest 0, slot1 not ready -> commit_count=1, reg_wr_en=2'b00.
- Slot0 store addr 0x100, data 0xDEADBEEF, size 2 -> commit_count=0 that cycle; st_req=1 next cycle with st_* stable; st_ack after 3 cycles -> commit_count=1 in the ack cycle; st_req=0 the cycle after.
- Slot0 ALU dest 5, slot1 store -> only slot0 commits; next cycle the store is at slot0 and the store sequence starts.
- Both slots write dest 4 -> reg_wr_en=2'b10; data from slot1.
- Reset asserted while in ST_WAIT -> next cycle st_req=0, commit_count=0, FSM in IDLE, store not popped; with COMMIT_STATS_EN, counters read 0.
